frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Game-loop scheduler between the game control FSM, the wall/dude datapath and `vga_adapter`. While `ingame` is high it generates a periodic game tick. On each tick it requests one datapath step over a req/done handshake, then owns the VGA plot port for one redraw. The redraw sweeps the playfield wall bitmap through a 1-cycle-latency read port, then paints the dude sprite over it.

## Interface
- `TICK_CYCLES`, 833333: clock cycles per game tick (60 Hz at 50 MHz); must be ≥ 2.
- `PF_W`, 120: playfield width in pixels (columns).
- `PF_H`, 100: playfield height in pixels (rows).
- `X0`, 20: screen x of playfield column 0.
- `Y0`, 10: screen y of playfield row 0.
- `DUDE_W`, 4: sprite width.
- `DUDE_H`, 6: sprite height.

Ports:
- `clk` in 1: single clock; everything is `posedge clk`.
- `resetn` in 1: asynchronous, active-low reset.
- `ingame` in 1: level from control; 1 = game running.
- `step_req` out 1: request one datapath update.
- `step_done` in 1: one-cycle pulse from datapath; update finished.
- `rd_en` out 1: wall read strobe.
- `rd_x` out 7: playfield column to read.
- `rd_y` out 7: playfield row to read.
- `wall_bit` in 1: wall pixel; valid the cycle after `rd_en`.
- `dude_x` in 7: sprite left column, playfield coords; sampled at WALLS entry.
- `dude_y` in 7: sprite top row, playfield coords; sampled at WALLS entry.
- `x` out 8: screen x to `vga_adapter`.
- `y` out 7: screen y to `vga_adapter`.
- `colour` out 3: pixel colour to `vga_adapter`.
- `plot` out 1: write strobe to `vga_adapter`.
- `frame_done` out 1: one-cycle pulse after the last sprite pixel.
- `overrun` out 1: sticky; a tick arrived while a frame was in progress.

## Operation
- FSM states: IDLE, WAIT_TICK, STEP, WALLS, DUDE.
- IDLE
  - Entered on reset or whenever `ingame` is low; `ingame` low in any state forces IDLE on the next edge (abort).
  - Clears the tick counter, the pending-tick flag and `overrun`.
  - `ingame` high → WAIT_TICK.
- Tick counter
  - Runs in every state except IDLE, counting 0..`TICK_CYCLES`-1 and wrapping.
  - Tick = count equals `TICK_CYCLES`-1.
  - A tick outside WAIT_TICK sets a pending flag and sets `overrun` (sticky until IDLE).
  - Multiple missed ticks coalesce into one pending tick.
- WAIT_TICK: tick or pending flag → STEP; consuming the tick clears the pending flag.
- STEP
  - `step_req` held high.
  - When `step_done` is sampled high → WALLS; `step_req` is low from that edge.
- WALLS
  - Sweeps column-major: c = 0..`PF_W`-1 outer, r = 0..`PF_H`-1 inner.
  - Issues one read per cycle (`rd_en`=1, `rd_x`=c, `rd_y`=r).
  - The following cycle drives `plot`=1, `x`=`X0`+c, `y`=`Y0`+r, `colour`=111 if `wall_bit` else 000.
  - After the last read issue → DUDE; the last wall plot overlaps the first DUDE cycle.
- DUDE
  - Sweeps i = 0..`DUDE_W`-1 outer, j = 0..`DUDE_H`-1 inner, one pixel per cycle.
  - Each pixel: `colour`=100, `x`=`X0`+`dude_x`+i, `y`=`Y0`+`dude_y`+j.
  - A pixel with `dude_x`+i ≥ `PF_W` or `dude_y`+j ≥ `PF_H` is clipped: `plot`=0 that cycle, still consumes the cycle.
  - After the last pixel: `frame_done` pulses → WAIT_TICK.
- Arithmetic: coordinate sums are 8-bit unsigned. Clipping uses the playfield-relative sum, so no wrap reaches the screen.

## Timing
- Reset values: `step_req`=0, `rd_en`=0, `rd_x`=0, `rd_y`=0, `x`=0, `y`=0, `colour`=000, `plot`=0, `frame_done`=0, `overrun`=0, state IDLE.
- All outputs are registered.
- `step_done` arriving while `step_req` is low is ignored.
- `step_done` in the same cycle `step_req` first rises is accepted.
- Frame length from leaving STEP to `frame_done` = `PF_W`·`PF_H` + `DUDE_W`·`DUDE_H` + 1 cycles.
- Abort: the cycle after `ingame` is sampled low, `plot`, `rd_en`, `step_req` and `frame_done` are all 0. No partial pixel is emitted after that.
- `ingame` high again restarts from WAIT_TICK with the counter at 0.
- A tick coincident with `frame_done` is treated as arriving outside WAIT_TICK: it sets pending and `overrun`.

## Test plan
Parameters for all scenarios unless stated: `TICK_CYCLES`=16, `PF_W`=4, `PF_H`=3, `X0`=20, `Y0`=10, `DUDE_W`=2, `DUDE_H`=2.

- Reset mid-WALLS (`resetn` pulsed low asynchronously between edges) → all outputs at reset values immediately, before the next edge; state IDLE.
- `ingame` rises; `step_done` returned 3 cycles after `step_req` → `step_req` high exactly 16 cycles after `ingame` is sampled high and lasts 4 cycles.
- Walls with bitmap pattern `wall_bit` = (c==0) → 12 plots in the order (20,10),(20,11),(20,12),(21,10)…; first column colour 111, others 000; each plot 1 cycle after its read.
- `dude_x`=3, `dude_y`=2 → only pixel (23,12) plotted in 100; three clipped cycles with `plot`=0; `frame_done` 17 cycles after leaving STEP.
- `step_done` delayed 20 cycles → `overrun`=1; exactly one extra STEP follows, not two; `ingame` low then clears `overrun`.
- `ingame` dropped mid-DUDE → `plot`=0 and `frame_done`=0 from the next cycle on; FSM in IDLE.

Source files
------------

// File: rtl/frame_sequencer_if.sv
// Bundle between the frame sequencer and its neighbours: the game control
// level, the datapath step handshake, the wall bitmap read port and the
// vga_adapter plot port.
interface frame_sequencer_if;
    logic       ingame;
    logic       step_req;
    logic       step_done;
    logic       rd_en;
    logic [6:0] rd_x;
    logic [6:0] rd_y;
    logic       wall_bit;
    logic [6:0] dude_x;
    logic [6:0] dude_y;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       frame_done;
    logic       overrun;

    // Sequencer side
    modport master (
        input  ingame, step_done, wall_bit, dude_x, dude_y,
        output step_req, rd_en, rd_x, rd_y, x, y, colour, plot, frame_done, overrun
    );

    // Environment side (control, datapath, wall memory, VGA adapter)
    modport slave (
        output ingame, step_done, wall_bit, dude_x, dude_y,
        input  step_req, rd_en, rd_x, rd_y, x, y, colour, plot, frame_done, overrun
    );
endinterface

// File: rtl/frame_sequencer.sv
// Game-loop scheduler: periodic tick, one datapath step per tick, then a
// full redraw (wall bitmap sweep followed by the dude sprite) on the VGA
// plot port. Every output comes straight from a flop.
module frame_sequencer #(
    parameter int TICK_CYCLES = 833333,
    parameter int PF_W        = 120,
    parameter int PF_H        = 100,
    parameter int X0          = 20,
    parameter int Y0          = 10,
    parameter int DUDE_W      = 4,
    parameter int DUDE_H      = 6
) (
    input  logic               clk,
    input  logic               resetn,
    frame_sequencer_if.master  bus
);
    localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [6:0] LAST_C = 7'(PF_W - 1);
    localparam logic [6:0] LAST_R = 7'(PF_H - 1);
    localparam logic [6:0] LAST_I = 7'(DUDE_W - 1);
    localparam logic [6:0] LAST_J = 7'(DUDE_H - 1);
    localparam logic [7:0] PF_W8  = 8'(PF_W);
    localparam logic [7:0] PF_H8  = 8'(PF_H);
    localparam logic [7:0] X0_8   = 8'(X0);
    localparam logic [6:0] Y0_7   = 7'(Y0);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, STEP, WALLS, DUDE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          pend_q, overrun_q, fin_q;
    logic          step_req_q, rd_en_q, plot_q, frame_done_q;
    logic [6:0]    rd_x_q, rd_y_q, dx_q, dy_q, di_q, dj_q;
    logic [7:0]    x_q;
    logic [6:0]    y_q;
    logic [2:0]    colour_q;

    logic          tick;
    logic [7:0]    px, py, wall_sx, dude_sx;
    logic [6:0]    wall_sy, dude_sy;
    logic          clip;

    // Tick decode, screen coordinates and sprite clipping. Clipping looks at
    // the playfield-relative sum so a wrapped screen coordinate is never plotted.
    always_comb begin
        tick    = (cnt_q == TICK_LAST);
        px      = {1'b0, dx_q} + {1'b0, di_q};
        py      = {1'b0, dy_q} + {1'b0, dj_q};
        clip    = (px >= PF_W8) || (py >= PF_H8);
        wall_sx = X0_8 + {1'b0, rd_x_q};
        wall_sy = Y0_7 + rd_y_q;
        dude_sx = X0_8 + px;
        dude_sy = Y0_7 + py[6:0];
    end

    // Main FSM with tick counter, pending/overrun tracking and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;      cnt_q <= '0;        pend_q <= 1'b0;
            overrun_q <= 1'b0;    fin_q <= 1'b0;      step_req_q <= 1'b0;
            rd_en_q <= 1'b0;      rd_x_q <= '0;       rd_y_q <= '0;
            dx_q <= '0;           dy_q <= '0;         di_q <= '0;
            dj_q <= '0;           x_q <= '0;          y_q <= '0;
            colour_q <= '0;       plot_q <= 1'b0;     frame_done_q <= 1'b0;
        end else if (!bus.ingame) begin
            // Abort: silence every strobe on this edge so no partial pixel escapes
            state_q <= IDLE;      cnt_q <= '0;        pend_q <= 1'b0;
            overrun_q <= 1'b0;    fin_q <= 1'b0;      step_req_q <= 1'b0;
            rd_en_q <= 1'b0;      rd_x_q <= '0;       rd_y_q <= '0;
            x_q <= '0;            y_q <= '0;          colour_q <= '0;
            plot_q <= 1'b0;       frame_done_q <= 1'b0;
        end else begin
            plot_q       <= 1'b0;
            frame_done_q <= 1'b0;
            if (state_q != IDLE) begin
                cnt_q <= tick ? '0 : cnt_q + 1'b1;
                // Ticks missed while busy coalesce into a single pending one
                if (tick && state_q != WAIT_TICK) begin
                    pend_q    <= 1'b1;
                    overrun_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: state_q <= WAIT_TICK;
                WAIT_TICK: begin
                    if (tick || pend_q) begin
                        pend_q     <= 1'b0;
                        step_req_q <= 1'b1;
                        state_q    <= STEP;
                    end
                end
                STEP: begin
                    if (bus.step_done) begin
                        step_req_q <= 1'b0;
                        rd_en_q    <= 1'b1;
                        rd_x_q     <= '0;
                        rd_y_q     <= '0;
                        dx_q       <= bus.dude_x;
                        dy_q       <= bus.dude_y;
                        state_q    <= WALLS;
                    end
                end
                WALLS: begin
                    // wall_bit answers the read currently on rd_x/rd_y
                    plot_q   <= 1'b1;
                    x_q      <= wall_sx;
                    y_q      <= wall_sy;
                    colour_q <= bus.wall_bit ? 3'b111 : 3'b000;
                    if (rd_y_q == LAST_R) begin
                        rd_y_q <= '0;
                        if (rd_x_q == LAST_C) begin
                            rd_en_q <= 1'b0;
                            rd_x_q  <= '0;
                            di_q    <= '0;
                            dj_q    <= '0;
                            fin_q   <= 1'b0;
                            state_q <= DUDE;
                        end else begin
                            rd_x_q <= rd_x_q + 1'b1;
                        end
                    end else begin
                        rd_y_q <= rd_y_q + 1'b1;
                    end
                end
                DUDE: begin
                    if (fin_q) begin
                        fin_q        <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= WAIT_TICK;
                    end else begin
                        // Clipped pixels still burn their cycle with plot low
                        plot_q   <= !clip;
                        x_q      <= dude_sx;
                        y_q      <= dude_sy;
                        colour_q <= 3'b100;
                        if (dj_q == LAST_J) begin
                            dj_q <= '0;
                            if (di_q == LAST_I) fin_q <= 1'b1;
                            else                di_q  <= di_q + 1'b1;
                        end else begin
                            dj_q <= dj_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.step_req   = step_req_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_x       = rd_x_q;
    assign bus.rd_y       = rd_y_q;
    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.colour     = colour_q;
    assign bus.plot       = plot_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed scenarios plus randomized frames.
// Expected plot streams are built from the drawing rules when a step is
// handed over; a negedge monitor pops and compares them as the DUT plots.
module tb_frame_sequencer;
    localparam int TICK = 16, PW = 4, PH = 3, X0 = 20, Y0 = 10, DW = 2, DH = 2;
    localparam int NPIX = PW * PH;
    localparam int FLEN = NPIX + DW * DH + 1;

    typedef struct {
        int cyc;
        int x;
        int y;
        int col;
        bit fd;
    } item_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [NPIX-1:0] pat = '0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int fd_cyc = -1;
    item_t q[$];

    frame_sequencer_if bus();

    frame_sequencer #(
        .TICK_CYCLES(TICK), .PF_W(PW), .PF_H(PH), .X0(X0), .Y0(Y0),
        .DUDE_W(DW), .DUDE_H(DH)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Wall memory model: answers the read presented on rd_x/rd_y
    always_comb begin
        int idx;
        idx = int'(bus.rd_x) * PH + int'(bus.rd_y);
        bus.wall_bit = 1'b0;
        if (bus.rd_en && idx < NPIX) bus.wall_bit = pat[idx];
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference frame: walls column-major, one plot per cycle starting the
    // cycle after the handshake edge, then unclipped sprite pixels, then done.
    task automatic push_frame(input int L, input int dx, input int dy);
        item_t it;
        for (int c = 0; c < PW; c++)
            for (int r = 0; r < PH; r++) begin
                it.cyc = L + c * PH + r + 1;
                it.x = X0 + c; it.y = Y0 + r;
                it.col = pat[c * PH + r] ? 7 : 0; it.fd = 0;
                q.push_back(it);
            end
        for (int i = 0; i < DW; i++)
            for (int j = 0; j < DH; j++)
                if (dx + i < PW && dy + j < PH) begin
                    it.cyc = L + NPIX + i * DH + j + 1;
                    it.x = X0 + dx + i; it.y = Y0 + dy + j;
                    it.col = 4; it.fd = 0;
                    q.push_back(it);
                end
        it.cyc = L + FLEN; it.x = 0; it.y = 0; it.col = 0; it.fd = 1;
        q.push_back(it);
    endtask

    // Monitor: every plot / frame_done must match the head of the queue
    always @(negedge clk) begin
        item_t it;
        if (resetn && (bus.plot || bus.frame_done)) begin
            if (q.size() == 0) begin
                chk("spurious_output", {bus.plot, bus.frame_done}, 0);
            end else begin
                it = q.pop_front();
                chk("out_cycle", cyc, it.cyc);
                if (it.fd) begin
                    chk("frame_done", bus.frame_done, 1);
                    chk("plot_at_done", bus.plot, 0);
                    fd_cyc = cyc;
                end else begin
                    chk("plot", bus.plot, 1);
                    chk("plot_x", bus.x, it.x);
                    chk("plot_y", bus.y, it.y);
                    chk("plot_colour", bus.colour, it.col);
                end
            end
        end
    end

    // Wait for a step request, answer it dly cycles after it rose
    task automatic do_step(input int dly, input int dx, input int dy,
                           input logic [NPIX-1:0] p, output int R, output int L);
        int n;
        n = 0;
        while (!bus.step_req && n < 200) begin @(posedge clk); #1; n++; end
        R = cyc;
        L = cyc;
        chk("step_req_seen", bus.step_req, 1);
        if (!bus.step_req) return;
        while (cyc < R + dly) begin @(posedge clk); #1; end
        chk("step_req_held", bus.step_req, 1);
        pat = p;
        bus.dude_x = 7'(dx);
        bus.dude_y = 7'(dy);
        bus.step_done = 1'b1;
        L = cyc + 1;
        push_frame(L, dx, dy);
        @(posedge clk); #1;
        bus.step_done = 1'b0;
        chk("step_req_drop", bus.step_req, 0);
        chk("step_req_len", L - R, dly + 1);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        chk("frame_complete", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int r, l, e0;
        logic [31:0] rv;
        bus.ingame = 1'b0; bus.step_done = 1'b0; bus.dude_x = '0; bus.dude_y = '0;
        resetn = 1'b0;
        #1;
        chk("rst_step_req", bus.step_req, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_rd_xy", {bus.rd_x, bus.rd_y}, 0);
        chk("rst_xy", {bus.x, bus.y}, 0);
        chk("rst_colour", bus.colour, 0);
        chk("rst_plot", bus.plot, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_overrun", bus.overrun, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        // First tick, ignored early step_done, 3-cycle step latency, c==0 walls, clipped dude
        bus.ingame = 1'b1;
        e0 = cyc + 1;
        while (cyc < e0 + 3) begin @(posedge clk); #1; end
        bus.step_done = 1'b1;
        @(posedge clk); #1;
        bus.step_done = 1'b0;
        chk("early_done_ignored", bus.step_req, 0);
        do_step(3, 3, 2, 12'h007, r, l);
        chk("first_tick", r - e0, 16);
        wait_frame();
        chk("frame_len", fd_cyc - l, 17);

        // Randomized frames
        for (int n = 0; n < 6; n++) begin
            rv = $urandom;
            do_step(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), rv[NPIX-1:0], r, l);
            wait_frame();
            chk("frame_len_rand", fd_cyc - l, FLEN);
        end

        // Overrun: slow datapath, pending tick consumed right after frame_done
        bus.ingame = 1'b0;
        @(posedge clk); #1;
        chk("idle_overrun_clr", bus.overrun, 0);
        chk("idle_step_req", bus.step_req, 0);
        @(posedge clk); #1;
        bus.ingame = 1'b1;
        e0 = cyc + 1;
        do_step(19, 1, 0, 12'h5a5, r, l);
        chk("ovr_first_tick", r - e0, 16);
        chk("overrun_set", bus.overrun, 1);
        wait_frame();
        do_step(0, 2, 1, 12'hf0f, r, l);
        chk("pending_step_once", r - fd_cyc, 1);
        wait_frame();
        chk("overrun_sticky", bus.overrun, 1);
        bus.ingame = 1'b0;
        @(posedge clk); #1;
        chk("overrun_cleared", bus.overrun, 0);

        // Abort mid-DUDE
        bus.ingame = 1'b1;
        e0 = cyc + 1;
        do_step(1, 0, 0, 12'h3c3, r, l);
        chk("restart_tick", r - e0, 16);
        while (cyc < l + NPIX + 1) begin @(posedge clk); #1; end
        bus.ingame = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            chk("abort_quiet", {bus.plot, bus.frame_done, bus.rd_en, bus.step_req}, 0);
        end
        q.delete();

        // Asynchronous reset mid-WALLS
        bus.ingame = 1'b1;
        e0 = cyc + 1;
        do_step(0, 1, 1, 12'h0ff, r, l);
        chk("restart_tick2", r - e0, 16);
        while (cyc < l + 5) begin @(posedge clk); #1; end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("async_rst_rd_en", bus.rd_en, 0);
        chk("async_rst_plot", bus.plot, 0);
        chk("async_rst_all", {bus.step_req, bus.rd_x, bus.rd_y, bus.x, bus.y,
                              bus.colour, bus.frame_done, bus.overrun}, 0);
        q.delete();
        resetn = 1'b1;
        e0 = cyc + 1;
        do_step(2, 2, 2, 12'h924, r, l);
        chk("post_reset_tick", r - e0, 16);
        wait_frame();

        chk("queue_empty_end", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
